// File: rtl/serial_pkg.sv
// Shared definitions for bit-serial arithmetic blocks: state encoding and default width.
package serial_pkg;

  localparam int unsigned SER_W = 8;

  // 2'd3 is unused; controllers recover from it to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for serial_add_ctrl. SERIAL_ADD_SUB_EN adds the sub select.
interface serial_add_ctrl_if #(
   parameter int unsigned W = serial_pkg::SER_W
);
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
`ifdef SERIAL_ADD_SUB_EN
   logic         sub;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   modport master (
`ifdef SERIAL_ADD_SUB_EN
      output sub,
`endif
      output start, a_in, b_in,
      input  busy, done, sum, cout
   );

   modport slave (
`ifdef SERIAL_ADD_SUB_EN
      input  sub,
`endif
      input  start, a_in, b_in,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_fa_bit.sv
// One-bit combinational full adder slice for bit-serial datapaths.
module serial_fa_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_add_ctrl.sv
// W-bit adder built from one serial full-adder slice, LSB first, one bit per clock.
// Optional SERIAL_ADD_SUB_EN: sub=1 computes A-B via ~B and carry-in 1.
module serial_add_ctrl
   import serial_pkg::*;
#(
   parameter int unsigned W = SER_W
) (
   input  logic             clk,
   input  logic             reset,
   serial_add_ctrl_if.slave bus
);
   localparam int unsigned          CNT_W    = $clog2(W + 1);
   localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(W - 1);

   state_e           state_q, state_d;
   logic [W-1:0]     a_sh_q, b_sh_q, res_q, res_next, sum_q;
   logic             carry_q, cout_q;
   logic [CNT_W-1:0] count_q;
   logic             s_bit, c_bit;
   logic [W-1:0]     b_load;
   logic             carry_load;

   serial_fa_bit u_fa (
      .a   (a_sh_q[0]),
      .b   (b_sh_q[0]),
      .cin (carry_q),
      .s   (s_bit),
      .co  (c_bit)
   );

`ifdef SERIAL_ADD_SUB_EN
   assign b_load     = bus.sub ? ~bus.b_in : bus.b_in;
   assign carry_load = bus.sub;
`else
   assign b_load     = bus.b_in;
   assign carry_load = 1'b0;
`endif

   always_comb begin
      res_next        = res_q >> 1;
      res_next[W-1]   = s_bit;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (count_q == LAST_CNT) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_sh_q  <= bus.a_in;
                  b_sh_q  <= b_load;
                  carry_q <= carry_load;
                  count_q <= '0;
               end
            end
            RUN: begin
               a_sh_q  <= a_sh_q >> 1;
               b_sh_q  <= b_sh_q >> 1;
               res_q   <= res_next;
               carry_q <= c_bit;
               count_q <= count_q + CNT_W'(1);
               // Publish the result only on the final bit so sum/cout stay stable otherwise.
               if (count_q == LAST_CNT) begin
                  sum_q  <= res_next;
                  cout_q <= c_bit;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule
